text_ram_scheduler: RTL and testbench
=====================================

// Module: text_ram_scheduler
// PURPOSE
//  Owns the single-port 80x60 text RAM and shares it between the display scan and a writer port.
//  The display scan has fixed priority and fetches one char code per 8-px cell into videoGen.
//  Writer requests (valid/ready, 4-deep FIFO) and a clear-screen FSM use the remaining free cycles.
//  Sits between vgaController (x, y, blank_b) and videoGen/chargenrom (charcode).
// PARAMETERS
//  COLS        80     text columns (640/8)
//  ROWS        60     text rows (480/8)
//  FIFO_DEPTH  4      writer FIFO entries; power of 2
//  CLEAR_CHAR  8'h20  code written by the clear FSM
// PORTS
//  vgaclk     in   1   pixel clock; the only clock
//  reset      in   1   synchronous, active-high
//  x, y       in   10  pixel counters from vgaController
//  blank_b    in   1   1 = active display area
//  wr_valid   in   1   writer request valid
//  wr_ready   out  1   FIFO can accept a request (not full, FSM IDLE)
//  wr_col     in   7   target column
//  wr_row     in   6   target row
//  wr_char    in   8   char code to store
//  wr_drop    out  1   1-cycle pulse: accepted request was out of range and discarded
//  clr_req    in   1   start clear-screen (pulse or level; sampled in IDLE only)
//  clr_busy   out  1   1 while FSM is in DRAIN or CLEAR
//  ram_addr   out  13  RAM address = row*COLS + col
//  ram_we     out  1   RAM write enable
//  ram_wdata  out  8   RAM write data
//  ram_rdata  in   8   RAM read data; synchronous, valid 1 cycle after address
//  charcode   out  8   current cell's char code to chargenrom
// BEHAVIOUR
//  Reset: wr_ready=0 in the reset cycle, then 1; wr_drop=0, clr_busy=0, ram_we=0, ram_addr=0,
//   ram_wdata=0, charcode=CLEAR_CHAR; FIFO emptied; FSM=IDLE. RAM contents are untouched.
//  Display slot: cycle with blank_b=1 and x[2:0]==0. ram_addr={y[9:3]*COLS + x[9:3]}, ram_we=0.
//   ram_rdata is registered into charcode the following cycle (x[2:0]==1 + 1 edge) -> latency 2 px.
//   videoGen delays xoff/yoff by 2 cycles to match. charcode holds until the next display slot.
//   Outside active area charcode=CLEAR_CHAR (forced on the first cycle with blank_b=0).
//  Free slot: any cycle that is not a display slot. At most one RAM write per free slot.
//  Writer: handshake completes when wr_valid && wr_ready on a rising edge; the entry is pushed.
//   Range check on push: col>=COLS or row>=ROWS -> not stored, wr_drop=1 next cycle.
//   Pop: FIFO head is written (ram_we=1) in the next free slot; FIFO order preserved.
//   Push and pop in the same cycle are allowed when full (count unchanged); wr_ready stays
//   deasserted when full, even if a pop occurs that cycle (registered ready, no bypass).
//  Clear FSM (states IDLE, DRAIN, CLEAR):
//   IDLE  -> DRAIN on clr_req; wr_ready=0 from the next cycle.
//   DRAIN: FIFO pops continue; -> CLEAR once the FIFO is empty.
//   CLEAR: writes CLEAR_CHAR at addresses 0..COLS*ROWS-1 (0..4799), one per free slot, in order;
//    -> IDLE after the write to 4799. The display may show a partial clear (no tearing protection).
//   clr_req in DRAIN or CLEAR is ignored (no re-queue). clr_busy=1 in DRAIN and CLEAR.
//  Simultaneous clr_req and wr_valid in IDLE: the write is accepted (wr_ready was 1) and is
//   written during DRAIN before the clear, so it is overwritten.
//  Reset mid-operation: the FIFO is flushed and CLEAR is aborted; the remaining RAM is unspecified.
//  Width: row*COLS is computed at 13 bits; address never exceeds 4799 (range check guarantees it).
// STRUCTURE
//  Shared package vga_pkg: COLS, ROWS, CLEAR_CHAR, TEXT_ADDR_W=13, typedef wr_req_t
//   {col[6:0], row[5:0], ch[7:0]}, typedef enum clr_state_t {IDLE, DRAIN, CLEAR}.
//  Sub-module: sync_fifo (parameterised width/depth, registered full/empty) holds wr_req_t.
//  Top level: slot decode, address mux (display > FIFO pop > clear), FSM, charcode register.
// TESTING
//  1. Reset, preload RAM[5*80+3]=8'h41; scan x=24, y=40 -> ram_addr=403 at x=24;
//     charcode=8'h41 two cycles later.
//  2. Write (col 10, row 2, 8'h33) while blank_b=0 -> ram_we=1, ram_addr=170, ram_wdata=8'h33
//     within 2 cycles of the handshake.
//  3. Write (col 79, row 59) in an active line at x[2:0]==7 -> write skips the slot at x[2:0]==0;
//     addr 4799 is written at x[2:0]==1.
//  4. Push 4 back-to-back entries during display slots only -> wr_ready=0 after the 4th; 5th held;
//     order is preserved on drain.
//  5. Write (col 80, row 0) -> wr_drop pulses 1 cycle; no ram_we. Row 60 gives the same result.
//  6. clr_req with 2 entries queued -> DRAIN writes both, then CLEAR; 4800 writes of 8'h20 at
//     addresses 0..4799; clr_busy falls after the last write. Repeat with reset asserted at write
//     1000 -> clr_busy=0 and ram_we=0 next cycle.

Source files
------------

// File: rtl/text_ram_scheduler_pkg.sv
// Shared constants, request/state types and address helpers for the text RAM scheduler.
package text_ram_scheduler_pkg;

  localparam int COLS        = 80;
  localparam int ROWS        = 60;
  localparam int FIFO_DEPTH  = 4;
  localparam int TEXT_ADDR_W = 13;

  localparam logic [7:0]             CLEAR_CHAR = 8'h20;
  localparam logic [TEXT_ADDR_W-1:0] LAST_ADDR  = 13'd4799;

  typedef struct packed {
    logic [6:0] col;
    logic [5:0] row;
    logic [7:0] ch;
  } wr_req_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } clr_state_t;

  // Linear cell address; row*COLS fits in 13 bits for every legal cell.
  function automatic logic [TEXT_ADDR_W-1:0] cell_addr(input logic [6:0] row, input logic [6:0] col);
    cell_addr = ({6'd0, row} * 13'd80) + {6'd0, col};
  endfunction

  function automatic logic in_range(input logic [6:0] col, input logic [5:0] row);
    in_range = (col < 7'd80) && (row < 6'd60);
  endfunction

endpackage

// File: rtl/text_ram_scheduler_if.sv
// Writer request channel: valid/ready handshake plus the out-of-range drop pulse.
interface text_ram_scheduler_if;
  logic       wr_valid;
  logic       wr_ready;
  logic [6:0] wr_col;
  logic [5:0] wr_row;
  logic [7:0] wr_char;
  logic       wr_drop;

  modport master (output wr_valid, wr_col, wr_row, wr_char, input wr_ready, wr_drop);
  modport slave  (input wr_valid, wr_col, wr_row, wr_char, output wr_ready, wr_drop);
endinterface

// File: rtl/text_ram_scheduler_fifo.sv
// Synchronous FIFO with registered full/empty; full_next lets the owner register its ready.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic             full_next
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_next_s;
  logic             full_r;
  logic             empty_r;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign pop_ok_s  = pop && !empty_r;
  assign push_ok_s = push && (!full_r || pop_ok_s);
  assign dout      = mem_r[rd_ptr_r];
  assign full      = full_r;
  assign empty     = empty_r;
  assign full_next = (count_next_s == CW'(DEPTH));

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next_s = count_r;
    if (push_ok_s && !pop_ok_s) begin
      count_next_s = count_r + {{(CW-1){1'b0}}, 1'b1};
    end else if (!push_ok_s && pop_ok_s) begin
      count_next_s = count_r - {{(CW-1){1'b0}}, 1'b1};
    end else begin
      count_next_s = count_r;
    end
  end

  // Pointers, count and flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
      count_r <= count_next_s;
      full_r  <= (count_next_s == CW'(DEPTH));
      empty_r <= (count_next_s == {CW{1'b0}});
    end
  end

  // Storage array; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (push_ok_s) mem_r[wr_ptr_r] <= din;
  end

endmodule

// File: rtl/text_ram_scheduler.sv
// Arbitrates the single-port text RAM: display fetch first, then queued writes, then screen clear.
module text_ram_scheduler
  import text_ram_scheduler_pkg::*;
(
  input  logic                   vgaclk,
  input  logic                   reset,
  input  logic [9:0]             x,
  input  logic [9:0]             y,
  input  logic                   blank_b,
  text_ram_scheduler_if.slave    wr,
  input  logic                   clr_req,
  output logic                   clr_busy,
  output logic [TEXT_ADDR_W-1:0] ram_addr,
  output logic                   ram_we,
  output logic [7:0]             ram_wdata,
  input  logic [7:0]             ram_rdata,
  output logic [7:0]             charcode
);

  clr_state_t             state_r, state_next_s;
  logic [TEXT_ADDR_W-1:0] clr_addr_r;
  logic                   wr_ready_r, wr_drop_r, clr_busy_r, disp_d_r;
  logic [7:0]             charcode_r;
  logic                   disp_slot_s, free_slot_s, accept_s, range_ok_s;
  logic                   push_s, pop_s, clr_write_s;
  logic                   fifo_full_s, fifo_empty_s, fifo_full_next_s;
  wr_req_t                push_req_s, head_s;
  logic                   unused_s;

  assign unused_s    = ^{y[2:0], fifo_full_s};
  assign disp_slot_s = blank_b && (x[2:0] == 3'd0);
  assign free_slot_s = !disp_slot_s;
  assign push_req_s  = '{col: wr.wr_col, row: wr.wr_row, ch: wr.wr_char};
  assign accept_s    = wr.wr_valid && wr_ready_r;
  assign range_ok_s  = in_range(wr.wr_col, wr.wr_row);
  assign push_s      = accept_s && range_ok_s;
  assign pop_s       = free_slot_s && !fifo_empty_s;
  assign clr_write_s = free_slot_s && fifo_empty_s && (state_r == CLEAR);

  assign wr.wr_ready = wr_ready_r;
  assign wr.wr_drop  = wr_drop_r;
  assign clr_busy    = clr_busy_r;
  assign charcode    = charcode_r;

  sync_fifo #(.WIDTH($bits(wr_req_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (vgaclk),
    .reset     (reset),
    .push      (push_s),
    .din       (push_req_s),
    .pop       (pop_s),
    .dout      (head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .full_next (fifo_full_next_s)
  );

  // Clear-screen sequencer next state.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE:    if (clr_req) state_next_s = DRAIN; else state_next_s = IDLE;
      DRAIN:   if (fifo_empty_s) state_next_s = CLEAR; else state_next_s = DRAIN;
      CLEAR:   if (clr_write_s && (clr_addr_r == LAST_ADDR)) state_next_s = IDLE;
               else state_next_s = CLEAR;
      default: state_next_s = IDLE;
    endcase
  end

  // RAM port mux: display slot owns the port, free slots carry at most one write.
  always_comb begin
    ram_addr  = {TEXT_ADDR_W{1'b0}};
    ram_we    = 1'b0;
    ram_wdata = 8'h00;
    if (reset) begin
      ram_we = 1'b0;
    end else if (disp_slot_s) begin
      ram_addr = cell_addr(y[9:3], x[9:3]);
    end else if (pop_s) begin
      ram_addr  = cell_addr({1'b0, head_s.row}, head_s.col);
      ram_we    = 1'b1;
      ram_wdata = head_s.ch;
    end else if (clr_write_s) begin
      ram_addr  = clr_addr_r;
      ram_we    = 1'b1;
      ram_wdata = CLEAR_CHAR;
    end else begin
      ram_we = 1'b0;
    end
  end

  // Sequencer state, handshake flags and the char code pipeline stage.
  always_ff @(posedge vgaclk) begin
    if (reset) begin
      state_r    <= IDLE;
      clr_addr_r <= {TEXT_ADDR_W{1'b0}};
      wr_ready_r <= 1'b0;
      wr_drop_r  <= 1'b0;
      clr_busy_r <= 1'b0;
      disp_d_r   <= 1'b0;
      charcode_r <= CLEAR_CHAR;
    end else begin
      state_r    <= state_next_s;
      wr_ready_r <= (state_next_s == IDLE) && !fifo_full_next_s;
      wr_drop_r  <= accept_s && !range_ok_s;
      clr_busy_r <= (state_next_s != IDLE);
      disp_d_r   <= disp_slot_s;
      if (state_r != CLEAR) begin
        clr_addr_r <= {TEXT_ADDR_W{1'b0}};
      end else if (clr_write_s) begin
        clr_addr_r <= clr_addr_r + 13'd1;
      end else begin
        clr_addr_r <= clr_addr_r;
      end
      // RAM data lands one cycle after the display slot address.
      if (disp_d_r) begin
        charcode_r <= ram_rdata;
      end else if (!blank_b) begin
        charcode_r <= CLEAR_CHAR;
      end else begin
        charcode_r <= charcode_r;
      end
    end
  end

endmodule

// File: tb/tb_text_ram_scheduler.sv
// Scoreboard bench: expected RAM writes/drops queued at issue time, checked by a monitor.
module tb_text_ram_scheduler;
  import text_ram_scheduler_pkg::*;

  logic        vgaclk = 1'b0;
  logic        reset;
  logic [9:0]  x, y;
  logic        blank_b;
  logic        clr_req;
  logic        clr_busy;
  logic [12:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  charcode;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [20:0] exp_q[$];
  int          drop_q[$];
  logic [20:0] e;

  logic [7:0]  tb_ram [0:8191];
  logic        pre_we;
  logic [12:0] pre_addr;
  logic [7:0]  pre_data;

  int          mode;
  logic [9:0]  scan_x = 10'd0;
  logic [9:0]  scan_y = 10'd0;
  logic [9:0]  man_x, man_y;
  logic        man_blank;

  text_ram_scheduler_if wif();

  text_ram_scheduler dut (
    .vgaclk    (vgaclk),
    .reset     (reset),
    .x         (x),
    .y         (y),
    .blank_b   (blank_b),
    .wr        (wif),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .charcode  (charcode)
  );

  always #5 vgaclk = ~vgaclk;

  // mode 0: blanked, 1: free-running raster, 2: every cycle a display slot, 3: manual
  assign x       = (mode == 3) ? man_x : (mode == 2) ? 10'd0 : scan_x;
  assign y       = (mode == 3) ? man_y : (mode == 2) ? 10'd0 : scan_y;
  assign blank_b = (mode == 3) ? man_blank : (mode == 2) ? 1'b1 :
                   (mode == 1) ? ((scan_x < 10'd640) && (scan_y < 10'd480)) : 1'b0;

  initial forever begin
    @(posedge vgaclk); #1;
    if (scan_x == 10'd799) begin
      scan_x = 10'd0;
      scan_y = (scan_y == 10'd524) ? 10'd0 : scan_y + 10'd1;
    end else begin
      scan_x = scan_x + 10'd1;
    end
  end

  // Synchronous single-port RAM model plus a cycle counter.
  always @(posedge vgaclk) begin
    cyc <= cyc + 1;
    if (pre_we) tb_ram[pre_addr] <= pre_data;
    else if (ram_we) tb_ram[ram_addr] <= ram_wdata;
    ram_rdata <= tb_ram[ram_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every RAM write and drop pulse is matched against the queued expectations.
  always @(negedge vgaclk) begin
    if (ram_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; failures++;
        $display("FAIL unexpected_write actual=%0h/%0h required=none", ram_addr, ram_wdata);
      end else begin
        e = exp_q.pop_front();
        check("ram_write", {11'd0, ram_addr, ram_wdata}, {11'd0, e});
      end
    end
    if (drop_q.size() > 0 && drop_q[0] < cyc) begin
      void'(drop_q.pop_front());
      checks++; failures++;
      $display("FAIL wr_drop_missed actual=0 required=1");
    end
    if (drop_q.size() > 0 && drop_q[0] == cyc) begin
      void'(drop_q.pop_front());
      check("wr_drop", {31'd0, wif.wr_drop}, 32'd1);
    end else if (wif.wr_drop === 1'b1) begin
      checks++; failures++;
      $display("FAIL wr_drop_unexpected actual=1 required=0");
    end
  end

  task automatic tick();
    @(posedge vgaclk); #1;
  endtask

  // Offer one request; the expectation is queued when the handshake edge is known.
  task automatic send(input logic [6:0] col, input logic [5:0] row, input logic [7:0] ch);
    bit done;
    int n;
    done = 1'b0;
    n = 0;
    wif.wr_valid = 1'b1; wif.wr_col = col; wif.wr_row = row; wif.wr_char = ch;
    while (!done && n < 3000) begin
      @(negedge vgaclk);
      if (wif.wr_ready === 1'b1) begin
        if (col < 7'd80 && row < 6'd60) exp_q.push_back({13'(int'(row) * 80 + int'(col)), ch});
        else drop_q.push_back(cyc + 1);
        done = 1'b1;
      end
      tick();
      n++;
    end
    wif.wr_valid = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=no_ready required=ready");
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin tick(); n++; end
    check(name, exp_q.size(), 0);
  endtask

  task automatic queue_clear();
    for (int a = 0; a < 4800; a++) exp_q.push_back({13'(a), CLEAR_CHAR});
  endtask

  initial begin
    int n;
    bit found;
    reset = 1'b1; mode = 0; clr_req = 1'b0; pre_we = 1'b0; pre_addr = 13'd0; pre_data = 8'h00;
    man_x = 10'd0; man_y = 10'd0; man_blank = 1'b0;
    wif.wr_valid = 1'b0; wif.wr_col = 7'd0; wif.wr_row = 6'd0; wif.wr_char = 8'h00;

    tick();
    pre_we = 1'b1; pre_addr = 13'd403; pre_data = 8'h41;
    tick();
    pre_we = 1'b0;
    @(negedge vgaclk);
    check("rst_wr_ready", {31'd0, wif.wr_ready}, 32'd0);
    check("rst_wr_drop", {31'd0, wif.wr_drop}, 32'd0);
    check("rst_clr_busy", {31'd0, clr_busy}, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_ram_addr", {19'd0, ram_addr}, 32'd0);
    check("rst_ram_wdata", {24'd0, ram_wdata}, 32'd0);
    check("rst_charcode", {24'd0, charcode}, 32'h20);
    tick();
    reset = 1'b0;
    @(negedge vgaclk);
    check("ready_last_reset_cycle", {31'd0, wif.wr_ready}, 32'd0);
    tick();
    @(negedge vgaclk);
    check("ready_after_reset", {31'd0, wif.wr_ready}, 32'd1);
    tick();

    // display fetch: cell (row 5, col 3)
    mode = 3; man_blank = 1'b1; man_x = 10'd24; man_y = 10'd40;
    @(negedge vgaclk);
    check("disp_addr", {19'd0, ram_addr}, 32'd403);
    check("disp_no_we", {31'd0, ram_we}, 32'd0);
    tick(); man_x = 10'd25;
    tick(); man_x = 10'd26;
    @(negedge vgaclk);
    check("charcode_latency", {24'd0, charcode}, 32'h41);
    tick(); man_x = 10'd31;
    @(negedge vgaclk);
    check("charcode_hold", {24'd0, charcode}, 32'h41);
    tick(); man_blank = 1'b0;
    tick();
    @(negedge vgaclk);
    check("charcode_blank", {24'd0, charcode}, 32'h20);
    tick();

    // write while blanked lands within two cycles
    mode = 0;
    send(7'd10, 6'd2, 8'h33);
    found = 1'b0;
    repeat (2) begin
      @(negedge vgaclk);
      if (ram_we === 1'b1 && ram_addr == 13'd170 && ram_wdata == 8'h33) found = 1'b1;
      tick();
    end
    check("write_latency", {31'd0, found}, 32'd1);

    // handshake at x[2:0]==7: display slot first, write in the next cycle
    mode = 3; man_blank = 1'b1; man_y = 10'd16; man_x = 10'd7;
    send(7'd79, 6'd59, 8'h5A);
    man_x = 10'd8;
    @(negedge vgaclk);
    check("slot_skip_we", {31'd0, ram_we}, 32'd0);
    check("slot_skip_addr", {19'd0, ram_addr}, 32'd161);
    tick(); man_x = 10'd9;
    @(negedge vgaclk);
    check("last_cell_we", {31'd0, ram_we}, 32'd1);
    check("last_cell_addr", {19'd0, ram_addr}, 32'd4799);
    tick();

    // fill the FIFO while every cycle is a display slot
    mode = 2;
    for (int i = 0; i < 4; i++) send(7'(i + 20), 6'(i + 1), 8'(8'h60 + i));
    @(negedge vgaclk);
    check("full_ready_low", {31'd0, wif.wr_ready}, 32'd0);
    tick();
    wif.wr_valid = 1'b1; wif.wr_col = 7'd30; wif.wr_row = 6'd9; wif.wr_char = 8'h70;
    repeat (4) begin
      @(negedge vgaclk);
      check("fifth_held", {31'd0, wif.wr_ready}, 32'd0);
      tick();
    end
    check("full_no_writes", exp_q.size(), 4);
    wif.wr_valid = 1'b0;
    mode = 0;
    send(7'd30, 6'd9, 8'h70);
    wait_drain("fifo_order_drain");

    // out-of-range requests are dropped
    send(7'd80, 6'd0, 8'h11);
    send(7'd0, 6'd60, 8'h12);
    send(7'd127, 6'd63, 8'h13);
    repeat (3) tick();
    check("drops_seen", drop_q.size(), 0);

    // randomized writes against a running raster
    mode = 1;
    for (int i = 0; i < 150; i++) begin
      send(7'($urandom_range(0, 84)), 6'($urandom_range(0, 63)), 8'($urandom));
      repeat ($urandom_range(0, 3)) tick();
    end
    wait_drain("random_drain");

    // clear with two queued entries, plus an ignored clr_req mid-clear
    mode = 2;
    send(7'd1, 6'd1, 8'hAA);
    send(7'd2, 6'd1, 8'hBB);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    queue_clear();
    @(negedge vgaclk);
    check("clr_busy_set", {31'd0, clr_busy}, 32'd1);
    check("clr_ready_low", {31'd0, wif.wr_ready}, 32'd0);
    tick();
    mode = 1;
    repeat (50) tick();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    n = 0;
    while (clr_busy === 1'b1 && n < 20000) begin tick(); n++; end
    @(negedge vgaclk);
    check("clear_complete", exp_q.size(), 0);
    check("clr_busy_low", {31'd0, clr_busy}, 32'd0);
    check("ready_after_clear", {31'd0, wif.wr_ready}, 32'd1);
    tick();

    // simultaneous write and clr_req, then reset at write 1000
    mode = 0;
    clr_req = 1'b1;
    send(7'd3, 6'd3, 8'hCC);
    clr_req = 1'b0;
    queue_clear();
    n = 0;
    found = 1'b0;
    while (!found && n < 20000) begin
      @(negedge vgaclk);
      if (ram_we === 1'b1 && ram_addr == 13'd1000) found = 1'b1;
      tick();
      n++;
    end
    check("reached_write_1000", {31'd0, found}, 32'd1);
    reset = 1'b1;
    exp_q.delete();
    tick();
    @(negedge vgaclk);
    check("abort_clr_busy", {31'd0, clr_busy}, 32'd0);
    check("abort_ram_we", {31'd0, ram_we}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    @(negedge vgaclk);
    check("abort_ready", {31'd0, wif.wr_ready}, 32'd1);
    check("abort_idle_we", {31'd0, ram_we}, 32'd0);

    repeat (4) tick();
    check("final_exp_empty", exp_q.size(), 0);
    check("final_drop_empty", drop_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
